// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin completion arbiter onto the common data bus
// One holding register per FU; one registered broadcast/remove per cycle.
module cdb_arbiter #(
  parameter int NUM_FU   = 4,
  parameter int PREG_W   = 6,
  parameter int RS_IDX_W = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [NUM_FU-1:0]            fu_valid,
  output logic [NUM_FU-1:0]            fu_ready,
  input  logic [NUM_FU*PREG_W-1:0]     fu_tag,
  input  logic [NUM_FU-1:0]            fu_has_dest,
  input  logic [NUM_FU*RS_IDX_W-1:0]   fu_rs_idx,
  output logic                         cdb_en,
  output logic [PREG_W-1:0]            cdb_tag,
  output logic                         remove_en,
  output logic [RS_IDX_W-1:0]          remove_idx,
  output logic                         pending
);

  localparam int PTR_W = $clog2(NUM_FU);

  logic [NUM_FU-1:0]                hold_valid_q, hold_valid_d;
  logic [NUM_FU-1:0][PREG_W-1:0]    hold_tag_q, hold_tag_d;
  logic [NUM_FU-1:0]                hold_dest_q, hold_dest_d;
  logic [NUM_FU-1:0][RS_IDX_W-1:0]  hold_rs_idx_q, hold_rs_idx_d;
  logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic                             cdb_en_q, cdb_en_d;
  logic [PREG_W-1:0]                cdb_tag_q, cdb_tag_d;
  logic                             remove_en_q, remove_en_d;
  logic [RS_IDX_W-1:0]              remove_idx_q, remove_idx_d;

  logic [NUM_FU-1:0] grant;
  logic              grant_any;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  cand;

  // Wraps explicitly so non-power-of-two NUM_FU never scans a missing slot.
  function automatic logic [PTR_W-1:0] scan_idx(input logic [PTR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_FU) s = s - NUM_FU;
    return PTR_W'(s);
  endfunction

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      cand = scan_idx(rr_ptr_q, k);
      if (!grant_any && hold_valid_q[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  assign fu_ready = ~hold_valid_q | grant;
  assign pending  = |hold_valid_q;

  always_comb begin
    hold_valid_d  = hold_valid_q;
    hold_tag_d    = hold_tag_q;
    hold_dest_d   = hold_dest_q;
    hold_rs_idx_d = hold_rs_idx_q;
    rr_ptr_d      = rr_ptr_q;
    cdb_en_d      = 1'b0;
    cdb_tag_d     = cdb_tag_q;
    remove_en_d   = 1'b0;
    remove_idx_d  = remove_idx_q;
    if (flush) begin
      hold_valid_d = '0;
      rr_ptr_d     = '0;
    end else begin
      if (grant_any) begin
        remove_en_d             = 1'b1;
        remove_idx_d            = hold_rs_idx_q[grant_idx];
        cdb_en_d                = hold_dest_q[grant_idx] && (hold_tag_q[grant_idx] != '0);
        cdb_tag_d               = hold_tag_q[grant_idx];
        hold_valid_d[grant_idx] = 1'b0;
        rr_ptr_d = (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
      // Loading after the grant clear lets a freed slot refill on the same edge.
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i] && fu_ready[i]) begin
          hold_valid_d[i]  = 1'b1;
          hold_tag_d[i]    = fu_tag[i*PREG_W +: PREG_W];
          hold_dest_d[i]   = fu_has_dest[i];
          hold_rs_idx_d[i] = fu_rs_idx[i*RS_IDX_W +: RS_IDX_W];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid_q <= '0;
      rr_ptr_q     <= '0;
      cdb_en_q     <= 1'b0;
      cdb_tag_q    <= '0;
      remove_en_q  <= 1'b0;
      remove_idx_q <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_en_q     <= cdb_en_d;
      cdb_tag_q    <= cdb_tag_d;
      remove_en_q  <= remove_en_d;
      remove_idx_q <= remove_idx_d;
    end
  end

  // Payload is qualified by hold_valid, so it needs no reset.
  always_ff @(posedge clock) begin
    hold_tag_q    <= hold_tag_d;
    hold_dest_q   <= hold_dest_d;
    hold_rs_idx_q <= hold_rs_idx_d;
  end

  assign cdb_en     = cdb_en_q;
  assign cdb_tag    = cdb_tag_q;
  assign remove_en  = remove_en_q;
  assign remove_idx = remove_idx_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed and randomized checks of cdb_arbiter
// Random phase compares against a queue-free array model of the holders.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int TW = 6;
  localparam int RW = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic [N-1:0]    fu_valid = '0;
  logic [N-1:0]    fu_ready;
  logic [N*TW-1:0] fu_tag = '0;
  logic [N-1:0]    fu_has_dest = '0;
  logic [N*RW-1:0] fu_rs_idx = '0;
  logic            cdb_en;
  logic [TW-1:0]   cdb_tag;
  logic            remove_en;
  logic [RW-1:0]   remove_idx;
  logic            pending;

  int vectors = 0;
  int errors  = 0;

  cdb_arbiter #(.NUM_FU(N), .PREG_W(TW), .RS_IDX_W(RW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_tag(fu_tag),
    .fu_has_dest(fu_has_dest), .fu_rs_idx(fu_rs_idx),
    .cdb_en(cdb_en), .cdb_tag(cdb_tag), .remove_en(remove_en),
    .remove_idx(remove_idx), .pending(pending)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    fu_valid = '0; fu_has_dest = '0; fu_tag = '0; fu_rs_idx = '0; flush = 1'b0;
  endtask

  task automatic set_fu(input int i, input logic [TW-1:0] tag, input logic dest, input logic [RW-1:0] rs);
    fu_valid[i] = 1'b1;
    fu_tag[i*TW +: TW] = tag;
    fu_has_dest[i] = dest;
    fu_rs_idx[i*RW +: RW] = rs;
  endtask

  task automatic do_flush();
    idle_inputs();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    cyc(); cyc();
    vectors++; if ({cdb_en, cdb_tag, remove_en, remove_idx} !== 11'd0) begin errors++; $display("FAIL reset_outputs: got %h exp %h", {cdb_en, cdb_tag, remove_en, remove_idx}, 11'd0); end
    vectors++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b exp 0", pending); end
    vectors++; if (fu_ready !== 4'hF) begin errors++; $display("FAIL reset_fu_ready: got %b exp 1111", fu_ready); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    set_fu(2, 6'h15, 1'b1, 3'd3);
    cyc();
    idle_inputs();
    vectors++; if ({cdb_en, remove_en} !== 2'b00) begin errors++; $display("FAIL single_n1_en: got %b exp 00", {cdb_en, remove_en}); end
    vectors++; if (pending !== 1'b1) begin errors++; $display("FAIL single_n1_pending: got %b exp 1", pending); end
    cyc();
    vectors++; if ({cdb_en, cdb_tag, remove_en, remove_idx} !== {1'b1, 6'h15, 1'b1, 3'd3}) begin errors++; $display("FAIL single_n2: got %h exp %h", {cdb_en, cdb_tag, remove_en, remove_idx}, {1'b1, 6'h15, 1'b1, 3'd3}); end
    cyc();
    vectors++; if ({cdb_en, remove_en, pending} !== 3'b000) begin errors++; $display("FAIL single_n3: got %b exp 000", {cdb_en, remove_en, pending}); end
  endtask

  task automatic test_contention();
    logic [10:0] exp_v;
    do_flush();
    for (int i = 0; i < N; i++) set_fu(i, 6'(17 + i), 1'b1, 3'(i));
    cyc();
    idle_inputs();
    set_fu(3, 6'h1C, 1'b1, 3'd7);
    for (int c = 1; c <= 6; c++) begin
      if (c <= 3) begin
        vectors++; if (fu_ready[3] !== 1'b0) begin errors++; $display("FAIL contention_ready3_c%0d: got %b exp 0", c, fu_ready[3]); end
      end
      if (c == 4) begin
        vectors++; if (fu_ready[3] !== 1'b1) begin errors++; $display("FAIL contention_ready3_c4: got %b exp 1", fu_ready[3]); end
      end
      if (c >= 2 && c <= 5) begin
        exp_v = {1'b1, 6'(17 + c - 2), 1'b1, 3'(c - 2)};
        vectors++; if ({cdb_en, cdb_tag, remove_en, remove_idx} !== exp_v) begin errors++; $display("FAIL contention_bcast_c%0d: got %h exp %h", c, {cdb_en, cdb_tag, remove_en, remove_idx}, exp_v); end
      end
      if (c == 6) begin
        vectors++; if ({cdb_en, cdb_tag, remove_en, remove_idx} !== {1'b1, 6'h1C, 1'b1, 3'd7}) begin errors++; $display("FAIL contention_stalled_fu3: got %h exp %h", {cdb_en, cdb_tag, remove_en, remove_idx}, {1'b1, 6'h1C, 1'b1, 3'd7}); end
      end
      if (c == 5) fu_valid[3] = 1'b0;
      cyc();
    end
    idle_inputs();
  endtask

  task automatic test_round_robin();
    int a, b, jj;
    logic [N-1:0] r;
    logic [10:0]  exp_v;
    do_flush();
    a = 0; b = 0;
    set_fu(0, 6'h20, 1'b1, 3'd1);
    set_fu(1, 6'h30, 1'b1, 3'd2);
    r = fu_ready;
    cyc();
    if (r[0]) a++;
    if (r[1]) b++;
    for (int j = 0; j <= 5; j++) begin
      set_fu(0, 6'(32 + a), 1'b1, 3'd1);
      set_fu(1, 6'(48 + b), 1'b1, 3'd2);
      vectors++; if (fu_ready[1:0] !== ((j % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rr_ready_j%0d: got %b exp %b", j, fu_ready[1:0], (j % 2 == 0) ? 2'b01 : 2'b10); end
      if (j >= 1) begin
        jj = j - 1;
        exp_v = (jj % 2 == 0) ? {1'b1, 6'(32 + jj / 2), 1'b1, 3'd1} : {1'b1, 6'(48 + jj / 2), 1'b1, 3'd2};
        vectors++; if ({cdb_en, cdb_tag, remove_en, remove_idx} !== exp_v) begin errors++; $display("FAIL rr_bcast_j%0d: got %h exp %h", j, {cdb_en, cdb_tag, remove_en, remove_idx}, exp_v); end
      end
      r = fu_ready;
      cyc();
      if (r[0]) a++;
      if (r[1]) b++;
    end
    idle_inputs();
  endtask

  task automatic test_store_tag0();
    do_flush();
    set_fu(1, 6'h2A, 1'b0, 3'd2);
    cyc(); idle_inputs(); cyc();
    vectors++; if ({cdb_en, remove_en, remove_idx} !== {1'b0, 1'b1, 3'd2}) begin errors++; $display("FAIL store_no_dest: got %b exp %b", {cdb_en, remove_en, remove_idx}, {1'b0, 1'b1, 3'd2}); end
    set_fu(0, 6'h00, 1'b1, 3'd5);
    cyc(); idle_inputs(); cyc();
    vectors++; if ({cdb_en, remove_en, remove_idx} !== {1'b0, 1'b1, 3'd5}) begin errors++; $display("FAIL tag0_dest: got %b exp %b", {cdb_en, remove_en, remove_idx}, {1'b0, 1'b1, 3'd5}); end
  endtask

  task automatic test_flush();
    do_flush();
    set_fu(1, 6'h05, 1'b1, 3'd1);
    cyc(); idle_inputs(); cyc();
    for (int i = 0; i < 3; i++) set_fu(i, 6'(40 + i), 1'b1, 3'(i));
    cyc();
    idle_inputs();
    vectors++; if (pending !== 1'b1) begin errors++; $display("FAIL flush_pre_pending: got %b exp 1", pending); end
    flush = 1'b1;
    set_fu(3, 6'h3F, 1'b1, 3'd6);
    cyc();
    idle_inputs();
    vectors++; if ({cdb_en, remove_en, pending} !== 3'b000) begin errors++; $display("FAIL flush_outputs: got %b exp 000", {cdb_en, remove_en, pending}); end
    vectors++; if (dut.rr_ptr_q !== 2'd0) begin errors++; $display("FAIL flush_rr_ptr: got %0d exp 0", dut.rr_ptr_q); end
    vectors++; if (fu_ready !== 4'hF) begin errors++; $display("FAIL flush_fu_ready: got %b exp 1111", fu_ready); end
    set_fu(3, 6'h27, 1'b1, 3'd4);
    cyc(); idle_inputs();
    vectors++; if (cdb_en !== 1'b0) begin errors++; $display("FAIL flush_fu3_n1: got %b exp 0", cdb_en); end
    cyc();
    vectors++; if ({cdb_en, cdb_tag, remove_en, remove_idx} !== {1'b1, 6'h27, 1'b1, 3'd4}) begin errors++; $display("FAIL flush_fu3_n2: got %h exp %h", {cdb_en, cdb_tag, remove_en, remove_idx}, {1'b1, 6'h27, 1'b1, 3'd4}); end
    cyc();
    vectors++; if ({cdb_en, remove_en} !== 2'b00) begin errors++; $display("FAIL flush_fu3_n3: got %b exp 00", {cdb_en, remove_en}); end
  endtask

  task automatic test_random();
    bit          mv[N];
    logic [TW-1:0] mtag[N];
    bit          mdest[N];
    logic [RW-1:0] mrs[N];
    int          mptr, mg;
    logic [N-1:0] mready;
    bit          e_cdb_en, e_rem_en;
    logic [TW-1:0] e_cdb_tag;
    logic [RW-1:0] e_rem_idx;
    reset = 1'b1; idle_inputs(); cyc(); reset = 1'b0;
    for (int i = 0; i < N; i++) begin mv[i] = 0; mtag[i] = '0; mdest[i] = 0; mrs[i] = '0; end
    mptr = 0; e_cdb_en = 0; e_rem_en = 0; e_cdb_tag = '0; e_rem_idx = '0;
    for (int t = 0; t < 300; t++) begin
      mg = -1;
      for (int k = 0; k < N; k++) if (mg < 0 && mv[(mptr + k) % N]) mg = (mptr + k) % N;
      for (int i = 0; i < N; i++) mready[i] = !mv[i] || (mg == i);
      flush = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < N; i++) begin
        if (!(fu_valid[i] && !mready[i])) begin
          fu_valid[i] = ($urandom_range(0, 2) != 0);
          fu_tag[i*TW +: TW] = ($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom_range(1, 63));
          fu_has_dest[i] = 1'($urandom_range(0, 1));
          fu_rs_idx[i*RW +: RW] = 3'($urandom_range(0, 7));
        end
      end
      vectors++; if (fu_ready !== mready) begin errors++; $display("FAIL rand_fu_ready t%0d: got %b exp %b", t, fu_ready, mready); end
      vectors++; if (pending !== (mv.or() != 0)) begin errors++; $display("FAIL rand_pending t%0d: got %b exp %b", t, pending, mv.or()); end
      if (flush) begin
        for (int i = 0; i < N; i++) mv[i] = 0;
        mptr = 0; e_cdb_en = 0; e_rem_en = 0;
      end else begin
        if (mg >= 0) begin
          e_rem_en = 1; e_rem_idx = mrs[mg];
          e_cdb_en = mdest[mg] && (mtag[mg] != 0);
          e_cdb_tag = mtag[mg];
          mv[mg] = 0;
          mptr = (mg + 1) % N;
        end else begin
          e_cdb_en = 0; e_rem_en = 0;
        end
        for (int i = 0; i < N; i++) begin
          if (fu_valid[i] && mready[i]) begin
            mv[i] = 1; mtag[i] = fu_tag[i*TW +: TW]; mdest[i] = fu_has_dest[i]; mrs[i] = fu_rs_idx[i*RW +: RW];
          end
        end
      end
      cyc();
      vectors++; if (cdb_en !== e_cdb_en) begin errors++; $display("FAIL rand_cdb_en t%0d: got %b exp %b", t, cdb_en, e_cdb_en); end
      vectors++; if (cdb_tag !== e_cdb_tag) begin errors++; $display("FAIL rand_cdb_tag t%0d: got %h exp %h", t, cdb_tag, e_cdb_tag); end
      vectors++; if (remove_en !== e_rem_en) begin errors++; $display("FAIL rand_remove_en t%0d: got %b exp %b", t, remove_en, e_rem_en); end
      vectors++; if (remove_idx !== e_rem_idx) begin errors++; $display("FAIL rand_remove_idx t%0d: got %0d exp %0d", t, remove_idx, e_rem_idx); end
    end
    idle_inputs();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_round_robin();
    test_store_tag0();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
